// File: rtl/counter_game_pkg.sv
// Shared types and the counter step model for the multimode counter game.
package counter_game_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, ARB, PLAY, SCORE, GAMEOVER} state_t;

  typedef enum logic [1:0] {INC1, INC2, DEC1, DEC2} mode_t;

  // Callers truncate the 32-bit result to the counter width, which gives the mod 2^N wrap.
  function automatic logic [31:0] step(input logic [31:0] shadow, input mode_t m);
    case (m)
      INC1:    step = shadow + 32'd1;
      INC2:    step = shadow + 32'd2;
      DEC1:    step = shadow - 32'd1;
      DEC2:    step = shadow - 32'd2;
      default: step = shadow;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int P  = 4,
  parameter int IW = $clog2(P)
) (
  input  logic [P-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [P-1:0]  gnt,
  output logic [IW-1:0] idx
);

  // Scan from ptr; the first hit wins.
  always_comb begin
    logic [IW-1:0] j_s;
    logic          found_s;
    gnt     = '0;
    idx     = '0;
    found_s = 1'b0;
    j_s     = '0;
    for (int k = 0; k < P; k++) begin
      j_s = IW'((int'(ptr) + k) % P);
      if (!found_s && req[j_s]) begin
        gnt[j_s] = 1'b1;
        idx      = j_s;
        found_s  = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/counter_game_scheduler.sv
// Turn scheduler sharing one external counter between P players; shadows the
// count, scores winner/loser events and declares a champion.
module counter_game_scheduler
  import counter_game_pkg::*;
#(
  parameter int N          = 4,
  parameter int P          = 4,
  parameter int TURN_CYC   = 4,
  parameter int WIN_TARGET = 3,
  parameter int SW         = $clog2(WIN_TARGET + 1),
  parameter int IW         = $clog2(P)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [N-1:0]    seed,
  input  logic [P-1:0]    req,
  input  logic [2*P-1:0]  mode,
  output logic [P-1:0]    grant,
  output logic            ctr_init,
  output logic            ctr_rst,
  output logic [N-1:0]    ctr_init_val,
  output logic [1:0]      ctr_control,
  input  logic            ctr_winner,
  input  logic            ctr_loser,
  output logic [SW*P-1:0] score,
  output logic            busy,
  output logic            game_over,
  output logic [IW-1:0]   champion,
  output logic            mismatch
);

  localparam int TW = $clog2(TURN_CYC) + 1;

  state_t        state_r, state_nxt_s;
  logic [N-1:0]  seed_q_r, shadow_r, shadow_nxt_s;
  logic [IW-1:0] ptr_r, gidx_r, gidx_inc_s, arb_idx_s, champion_r;
  logic [P-1:0]  arb_gnt_s, grant_r;
  logic [TW-1:0] turn_cnt_r;
  logic [SW*P-1:0] score_r;
  logic [SW-1:0] cur_score_s, new_score_s;
  logic          exp_win_r, exp_lose_r, mismatch_r;
  logic          g_req_s, event_s, turn_last_s;
  mode_t         g_mode_s;

  rr_arbiter #(.P(P), .IW(IW)) u_arb (
    .req (req),
    .ptr (ptr_r),
    .gnt (arb_gnt_s),
    .idx (arb_idx_s)
  );

  // Granted player's live inputs, its score, and the predicted counter step.
  always_comb begin
    g_mode_s    = INC1;
    cur_score_s = '0;
    for (int i = 0; i < P; i++) begin
      if (gidx_r == IW'(i)) begin
        g_mode_s    = mode_t'(mode[2*i +: 2]);
        cur_score_s = score_r[SW*i +: SW];
      end else begin
        g_mode_s    = g_mode_s;
      end
    end
    g_req_s      = req[gidx_r];
    shadow_nxt_s = N'(step(32'(shadow_r), g_mode_s));
    event_s      = (shadow_nxt_s == '1) || (shadow_nxt_s == '0);
    turn_last_s  = (turn_cnt_r == TW'(TURN_CYC - 1));
    gidx_inc_s   = (gidx_r == IW'(P - 1)) ? '0 : gidx_r + IW'(1);
    if (exp_win_r) begin
      new_score_s = cur_score_s + SW'(1);
    end else if (exp_lose_r && (cur_score_s != '0)) begin
      new_score_s = cur_score_s - SW'(1);
    end else begin
      new_score_s = cur_score_s;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // Next state and counter pins; non-PLAY busy cycles reload the counter so it cannot drift.
  always_comb begin
    state_nxt_s  = state_r;
    ctr_init     = 1'b0;
    ctr_rst      = 1'b0;
    ctr_init_val = '0;
    ctr_control  = 2'b00;
    case (state_r)
      IDLE, GAMEOVER: begin
        if (start) state_nxt_s = LOAD;
        else       state_nxt_s = state_r;
      end
      LOAD: begin
        ctr_init     = 1'b1;
        ctr_rst      = 1'b1;
        ctr_init_val = seed_q_r;
        state_nxt_s  = ARB;
      end
      ARB: begin
        ctr_init     = 1'b1;
        ctr_rst      = 1'b1;
        ctr_init_val = shadow_r;
        if (|req) state_nxt_s = PLAY;
        else      state_nxt_s = ARB;
      end
      PLAY: begin
        ctr_init_val = shadow_r;
        if (!g_req_s) begin
          ctr_init    = 1'b1;
          ctr_rst     = 1'b1;
          state_nxt_s = ARB;
        end else begin
          ctr_control = g_mode_s;
          if (event_s)          state_nxt_s = SCORE;
          else if (turn_last_s) state_nxt_s = ARB;
          else                  state_nxt_s = PLAY;
        end
      end
      SCORE: begin
        ctr_init     = 1'b1;
        ctr_rst      = 1'b1;
        ctr_init_val = seed_q_r;
        if (new_score_s == SW'(WIN_TARGET)) state_nxt_s = GAMEOVER;
        else                                state_nxt_s = ARB;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Game datapath: seed, shadow, grant/turn bookkeeping, scoring.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seed_q_r   <= '0;
      shadow_r   <= '0;
      ptr_r      <= '0;
      gidx_r     <= '0;
      grant_r    <= '0;
      turn_cnt_r <= '0;
      score_r    <= '0;
      exp_win_r  <= 1'b0;
      exp_lose_r <= 1'b0;
      mismatch_r <= 1'b0;
      champion_r <= '0;
    end else begin
      case (state_r)
        IDLE, GAMEOVER: begin
          if (start) begin
            seed_q_r   <= seed;
            shadow_r   <= seed;
            score_r    <= '0;
            mismatch_r <= 1'b0;
            champion_r <= '0;
          end
        end
        ARB: begin
          if (|req) begin
            grant_r    <= arb_gnt_s;
            gidx_r     <= arb_idx_s;
            turn_cnt_r <= '0;
          end
        end
        PLAY: begin
          if (!g_req_s) begin
            grant_r <= '0;
            ptr_r   <= gidx_inc_s;
          end else begin
            shadow_r   <= shadow_nxt_s;
            turn_cnt_r <= turn_cnt_r + TW'(1);
            exp_win_r  <= (shadow_nxt_s == '1);
            exp_lose_r <= (shadow_nxt_s == '0);
            if (event_s || turn_last_s) begin
              grant_r <= '0;
              ptr_r   <= gidx_inc_s;
            end
          end
        end
        SCORE: begin
          if ((ctr_winner != exp_win_r) || (ctr_loser != exp_lose_r)) mismatch_r <= 1'b1;
          for (int i = 0; i < P; i++) begin
            if (gidx_r == IW'(i)) score_r[SW*i +: SW] <= new_score_s;
          end
          shadow_r <= seed_q_r;
          if (new_score_s == SW'(WIN_TARGET)) champion_r <= gidx_r;
        end
        default: begin
        end
      endcase
    end
  end

  assign grant     = grant_r;
  assign score     = score_r;
  assign mismatch  = mismatch_r;
  assign champion  = champion_r;
  assign game_over = (state_r == GAMEOVER);
  assign busy      = (state_r != IDLE) && (state_r != GAMEOVER);

endmodule
